prm_mask_loader: RTL and testbench

Writer side of the edge-mask path. Accepts a 32-bit valid/ready word stream from the host/config interface and assembles it into eight 512-bit edge masks (banks p0..p7). These registered masks drive the `edge_mask_512p0..p7` inputs of `prm_chk_v1_0`, in place of the fixed LUT generators, so masks can be reloaded at run time without resynthesis.

---
 rtl/prm_pkg.sv | 26 ++
 rtl/prm_mask_asm.sv | 43 ++++
 rtl/prm_mask_loader.sv | 143 ++++++++++++++
 tb/tb_prm_mask_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_pkg.sv
// Shared definitions for the edge-mask loader.
//   WORD_W  width of one config stream beat
//   MASK_W  width of one edge mask (multiple of WORD_W)
//   NBANK   number of mask banks
//   WPM     beats per mask
//   state_e loader FSM states
//   bank_idx_t  bank index carried on cfg_bank
package prm_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 512;
    localparam int unsigned NBANK  = 8;
    localparam int unsigned WPM    = MASK_W / WORD_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BANK_W = 3;

    typedef logic [BANK_W-1:0] bank_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StCommit
    } state_e;

endpackage

// File: rtl/prm_mask_asm.sv
// Shadow assembler: collects stream words into a MASK_W shadow register.
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset; clears counter and shadow
//   wr_i        write data_i into word slot cnt and advance cnt
//   clr_i       return cnt to 0 (takes effect after any write in the same cycle)
//   data_i      beat payload
//   shadow_o    assembled mask, word k at bits [k*WORD_W +: WORD_W]
//   complete_o  the next write fills the final word of the mask
module prm_mask_asm
    import prm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [MASK_W-1:0] shadow_o,
    output logic              complete_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [MASK_W-1:0] shadow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            if (wr_i) begin
                shadow_q[cnt_q*WORD_W +: WORD_W] <= data_i;
            end
            if (clr_i) begin
                cnt_q <= '0;
            end else if (wr_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign shadow_o   = shadow_q;
    assign complete_o = (cnt_q == CNT_W'(WPM - 1));

endmodule

// File: rtl/prm_mask_loader.sv
// Edge-mask loader: turns a 32-bit valid/ready config stream into eight
// registered 512-bit edge masks that feed prm_chk_v1_0 directly.
//   CLK, RST            clock and synchronous active-high reset
//   cfg_valid/ready     beat handshake; transfer when both high
//   cfg_data            beat payload, word 0 first
//   cfg_last            final beat of a mask
//   cfg_bank            target bank, sampled on the first beat only
//   mask_clr            pulse clearing all mask_valid bits (data kept)
//   edge_mask_512p0..7  committed bank contents
//   mask_valid          per-bank "holds a complete mask"
//   load_done           one-cycle pulse on commit
//   err_len             one-cycle pulse on a wrong-length mask
module prm_mask_loader
    import prm_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  bank_idx_t         cfg_bank,
    input  logic              mask_clr,
    output logic [MASK_W-1:0] edge_mask_512p0,
    output logic [MASK_W-1:0] edge_mask_512p1,
    output logic [MASK_W-1:0] edge_mask_512p2,
    output logic [MASK_W-1:0] edge_mask_512p3,
    output logic [MASK_W-1:0] edge_mask_512p4,
    output logic [MASK_W-1:0] edge_mask_512p5,
    output logic [MASK_W-1:0] edge_mask_512p6,
    output logic [MASK_W-1:0] edge_mask_512p7,
    output logic [NBANK-1:0]  mask_valid,
    output logic              load_done,
    output logic              err_len
);

    state_e            state_q;
    bank_idx_t         bank_sel_q;
    logic              cfg_ready_q;
    logic [NBANK-1:0]  mask_valid_q;
    logic              load_done_q;
    logic              err_len_q;
    logic [MASK_W-1:0] bank_q [NBANK];

    logic              beat;
    logic              asm_wr;
    logic              asm_clr;
    logic              complete;
    logic [MASK_W-1:0] shadow;

    assign beat = cfg_valid && cfg_ready_q;

    // A lone first beat that is also last never enters the shadow.
    assign asm_wr  = beat && (((state_q == StIdle) && !cfg_last) || (state_q == StLoad));
    // Leaving LOAD for any reason rewinds the counter, so IDLE always sees cnt=0.
    assign asm_clr = beat && (state_q == StLoad) && (cfg_last || complete);

    prm_mask_asm u_asm (
        .clk_i      (CLK),
        .rst_i      (RST),
        .wr_i       (asm_wr),
        .clr_i      (asm_clr),
        .data_i     (cfg_data),
        .shadow_o   (shadow),
        .complete_o (complete)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            bank_sel_q   <= '0;
            cfg_ready_q  <= 1'b0;
            mask_valid_q <= '0;
            load_done_q  <= 1'b0;
            err_len_q    <= 1'b0;
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            load_done_q <= 1'b0;
            err_len_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            if (mask_clr) begin
                mask_valid_q <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (beat) begin
                        if (cfg_last) begin
                            err_len_q <= 1'b1;
                        end else begin
                            bank_sel_q <= cfg_bank;
                            state_q    <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (beat) begin
                        if (cfg_last) begin
                            if (complete) begin
                                state_q     <= StCommit;
                                cfg_ready_q <= 1'b0;
                            end else begin
                                err_len_q <= 1'b1;
                                state_q   <= StIdle;
                            end
                        end else if (complete) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (beat && cfg_last) begin
                        err_len_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StCommit: begin
                    bank_q[bank_sel_q] <= shadow;
                    // Commit wins over a simultaneous clear for its own bank.
                    mask_valid_q <= (mask_clr ? '0 : mask_valid_q) | (NBANK'(1) << bank_sel_q);
                    load_done_q  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_ready       = cfg_ready_q;
    assign mask_valid      = mask_valid_q;
    assign load_done       = load_done_q;
    assign err_len         = err_len_q;
    assign edge_mask_512p0 = bank_q[0];
    assign edge_mask_512p1 = bank_q[1];
    assign edge_mask_512p2 = bank_q[2];
    assign edge_mask_512p3 = bank_q[3];
    assign edge_mask_512p4 = bank_q[4];
    assign edge_mask_512p5 = bank_q[5];
    assign edge_mask_512p6 = bank_q[6];
    assign edge_mask_512p7 = bank_q[7];

endmodule

// File: tb/tb_prm_mask_loader.sv
// Scoreboard bench for prm_mask_loader: a mask-level reference model predicts
// each commit or length error and the resulting bank/valid state; a monitor
// checks every load_done / err_len pulse against the queued prediction.
module tb_prm_mask_loader;
    import prm_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data = '0;
    logic              cfg_last = 1'b0;
    logic [2:0]        cfg_bank = '0;
    logic              mask_clr = 1'b0;
    logic [MASK_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
    logic [NBANK-1:0]  mask_valid;
    logic              load_done;
    logic              err_len;

    prm_mask_loader dut (
        .CLK             (CLK),
        .RST             (RST),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_data        (cfg_data),
        .cfg_last        (cfg_last),
        .cfg_bank        (cfg_bank),
        .mask_clr        (mask_clr),
        .edge_mask_512p0 (p0),
        .edge_mask_512p1 (p1),
        .edge_mask_512p2 (p2),
        .edge_mask_512p3 (p3),
        .edge_mask_512p4 (p4),
        .edge_mask_512p5 (p5),
        .edge_mask_512p6 (p6),
        .edge_mask_512p7 (p7),
        .mask_valid      (mask_valid),
        .load_done       (load_done),
        .err_len         (err_len)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [NBANK*MASK_W-1:0] dut_all;
    assign dut_all = {p7, p6, p5, p4, p3, p2, p1, p0};

    typedef struct {
        bit                      is_commit;
        int                      exp_cyc;
        logic [NBANK-1:0]        valid;
        logic [NBANK*MASK_W-1:0] banks;
    } ev_t;

    ev_t q[$];

    // Reference model: what the banks and valid bits should hold.
    logic [MASK_W-1:0] m_bank [NBANK];
    logic [NBANK-1:0]  m_valid;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [MASK_W-1:0] act,
                       input logic [MASK_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NBANK*MASK_W-1:0] snap();
        logic [NBANK*MASK_W-1:0] s;
        for (int i = 0; i < NBANK; i++) s[i*MASK_W +: MASK_W] = m_bank[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NBANK; i++) m_bank[i] = '0;
        m_valid = '0;
    endtask

    // Monitor: one pop per observed pulse.
    logic prev_ready = 1'b0;
    int   low_run = 0;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                low_run = 0;
            end else begin
                if (load_done || err_len) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected pulse: load_done=%0b err_len=%0b at cycle %0d",
                                 load_done, err_len, cyc);
                    end else begin
                        ev_t ev;
                        ev = q.pop_front();
                        chk("load_done vs err_len kind", {load_done, err_len},
                            ev.is_commit ? 2'b10 : 2'b01);
                        chk("pulse cycle", cyc, ev.exp_cyc);
                        chk("mask_valid", mask_valid, ev.valid);
                        for (int i = 0; i < NBANK; i++) begin
                            chk($sformatf("edge_mask bank %0d", i),
                                dut_all[i*MASK_W +: MASK_W], ev.banks[i*MASK_W +: MASK_W]);
                        end
                        if (ev.is_commit) begin
                            chk("cfg_ready low in commit cycle", prev_ready, 1'b0);
                            chk("cfg_ready back after commit", cfg_ready, 1'b1);
                        end
                    end
                end
                if (!cfg_ready) begin
                    low_run++;
                    chk("cfg_ready low for more than one cycle", low_run > 1, 1'b0);
                end else begin
                    low_run = 0;
                end
            end
            prev_ready = cfg_ready;
        end
    end

    // Offer one beat; returns the cycle stamp of the accepting edge.
    task automatic beat(input logic [WORD_W-1:0] d, input logic l, input logic [2:0] b,
                        output int acc);
        bit got;
        int w;
        got = 1'b0;
        w = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        cfg_bank  = b;
        while (!got && w < 100) begin
            @(negedge CLK);
            got = cfg_ready;
            @(posedge CLK);
            #1;
            w++;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat accept timeout: got no ready, required ready within 100 cycles");
        end
        acc = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic send_mask(input int bank, input int n, input bit ramp, input bit gaps,
                             input bit scramble, input bit clr_at_commit);
        logic [MASK_W-1:0] img;
        logic [WORD_W-1:0] d;
        logic [2:0]        b;
        int                acc;
        ev_t               ev;
        img = '0;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLK);
                    #1;
                end
            end
            d = ramp ? WORD_W'(k) : WORD_W'($urandom);
            if (k < int'(WPM)) img[k*WORD_W +: WORD_W] = d;
            b = (k == 0 || !scramble) ? 3'(bank) : 3'($urandom_range(0, 7));
            beat(d, k == n - 1, b, acc);
        end
        if (clr_at_commit) begin
            mask_clr = 1'b1;
            @(posedge CLK);
            #1;
            mask_clr = 1'b0;
            m_valid = '0;
        end
        if (n == int'(WPM)) begin
            m_bank[bank]  = img;
            m_valid[bank] = 1'b1;
            ev.is_commit  = 1'b1;
            ev.exp_cyc    = acc + 1;
        end else begin
            ev.is_commit = 1'b0;
            ev.exp_cyc   = acc;
        end
        ev.valid = m_valid;
        ev.banks = snap();
        q.push_back(ev);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge CLK);
            #1;
            w++;
        end
        chk("pending events drained", q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cfg_ready"}, cfg_ready, 1'b0);
        chk({tag, " mask_valid"}, mask_valid, '0);
        chk({tag, " load_done"}, load_done, 1'b0);
        chk({tag, " err_len"}, err_len, 1'b0);
        for (int i = 0; i < NBANK; i++) begin
            chk($sformatf("%s bank %0d", tag, i), dut_all[i*MASK_W +: MASK_W], '0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("cfg_ready after reset release", cfg_ready, 1'b1);

        // Ramp load to bank 3, immediately followed by a short mask to bank 1.
        send_mask(3, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        send_mask(1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_mask(1, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        // Overlong mask to bank 0 must leave bank 0 alone.
        send_mask(0, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single-beat mask errors straight out of idle.
        send_mask(6, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Stalled bank-7 load with cfg_bank wandering after the first beat.
        send_mask(7, 16, 1'b0, 1'b1, 1'b1, 1'b0);
        // Clear colliding with a bank-5 reload.
        send_mask(2, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        send_mask(5, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        send_mask(5, 16, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();
        chk("valid after clear/commit collision", mask_valid, 8'b0010_0000);

        // Reset in the middle of a bank-4 load.
        for (int k = 0; k < 7; k++) beat(WORD_W'($urandom), 1'b0, 3'd4, acc);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
        chk_reset_outputs("mid-load reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("cfg_ready after mid-load reset", cfg_ready, 1'b1);
        send_mask(4, 16, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 12; t++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 22)) : 16;
            send_mask(int'($urandom_range(0, 7)), n, 1'b0, bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), 1'b0);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
